// File: rtl/apb_gpio_irq_if.sv
// APB3 bus bundle for the GPIO peripheral.
// Signals: pADDR/pSEL/pENABLE/pWRITE/pWDATA driven by the master,
//          pRDATA/pREADY/pSLVERR driven by the slave.
// Modports: master (bus requester), slave (peripheral side).
interface apb_gpio_irq_if #(
    parameter int AW = 32,
    parameter int DW = 32
) ();
    logic [AW-1:0] pADDR;
    logic          pSEL;
    logic          pENABLE;
    logic          pWRITE;
    logic [DW-1:0] pWDATA;
    logic [DW-1:0] pRDATA;
    logic          pREADY;
    logic          pSLVERR;

    modport master (
        output pADDR, pSEL, pENABLE, pWRITE, pWDATA,
        input  pRDATA, pREADY, pSLVERR
    );

    modport slave (
        input  pADDR, pSEL, pENABLE, pWRITE, pWDATA,
        output pRDATA, pREADY, pSLVERR
    );
endinterface

// File: rtl/apb_gpio_irq.sv
// APB3 GPIO peripheral with per-pin direction, atomic output set/clear,
// synchronised inputs and rise/fall edge interrupts (sticky W1C status).
// Ports:
//   pCLK, pRESETn     clock, asynchronous active-low reset
//   bus (slave)       APB3 register access, pADDR[6:0] decoded
//   gpio_in           asynchronous pin inputs
//   gpio_out, gpio_oe output values / output enables (registered)
//   irq               level interrupt = OR of STATUS bits
module apb_gpio_irq #(
    parameter int DW          = 32,
    parameter int AW          = 32,
    parameter int NGPIO       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic               pCLK,
    input  logic               pRESETn,
    apb_gpio_irq_if.slave      bus,
    input  logic [NGPIO-1:0]   gpio_in,
    output logic [NGPIO-1:0]   gpio_out,
    output logic [NGPIO-1:0]   gpio_oe,
    output logic               irq
);

    typedef enum logic [2:0] {
        REG_DATA_IN  = 3'd0,
        REG_DATA_OUT = 3'd1,
        REG_DIR      = 3'd2,
        REG_RISE_EN  = 3'd3,
        REG_FALL_EN  = 3'd4,
        REG_STATUS   = 3'd5,
        REG_OUT_SET  = 3'd6,
        REG_OUT_CLR  = 3'd7
    } reg_idx_t;

    logic [6:0]       offset;
    reg_idx_t         idx;
    logic             access;
    logic             mapped;
    logic             err;
    logic             we;
    logic             re;
    logic [NGPIO-1:0] wdata;

    logic [SYNC_STAGES-1:0][NGPIO-1:0] sync_q;
    logic [NGPIO-1:0] sync_val;
    logic [NGPIO-1:0] prev_q;
    logic [NGPIO-1:0] rise;
    logic [NGPIO-1:0] fall;
    logic [NGPIO-1:0] set_ev;
    logic [NGPIO-1:0] w1c;

    logic [NGPIO-1:0] data_out_q;
    logic [NGPIO-1:0] dir_q;
    logic [NGPIO-1:0] rise_en_q;
    logic [NGPIO-1:0] fall_en_q;
    logic [NGPIO-1:0] status_q;

    logic [NGPIO-1:0] rd_sel;
    logic [DW-1:0]    rdata;
    logic             unused;

    assign offset = bus.pADDR[6:0];
    assign idx    = reg_idx_t'(offset[4:2]);
    assign access = bus.pSEL & bus.pENABLE;
    // Only word-aligned offsets below 0x20 hit a register.
    assign mapped = (offset[6:5] == 2'b00) && (offset[1:0] == 2'b00);
    assign err    = access & (~mapped | (bus.pWRITE & (idx == REG_DATA_IN)));
    assign we     = access & bus.pWRITE & ~err;
    assign re     = access & ~bus.pWRITE & ~err;
    assign wdata  = bus.pWDATA[NGPIO-1:0];

    assign unused = &{1'b0, bus.pADDR, bus.pWDATA};

    // Input synchroniser followed by the prev register for edge detection.
    always_ff @(posedge pCLK or negedge pRESETn) begin
        if (!pRESETn) begin
            sync_q <= '0;
            prev_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], gpio_in};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign sync_val = sync_q[SYNC_STAGES-1];
    assign rise     = sync_val & ~prev_q;
    assign fall     = ~sync_val & prev_q;
    assign set_ev   = (rise & rise_en_q) | (fall & fall_en_q);
    assign w1c      = (we && idx == REG_STATUS) ? wdata : '0;

    always_ff @(posedge pCLK or negedge pRESETn) begin
        if (!pRESETn) begin
            data_out_q <= '0;
            dir_q      <= '0;
            rise_en_q  <= '0;
            fall_en_q  <= '0;
            status_q   <= '0;
        end else begin
            // A same-cycle edge event overrides the clear of that bit.
            status_q <= (status_q & ~w1c) | set_ev;
            if (we) begin
                case (idx)
                    REG_DATA_OUT: data_out_q <= wdata;
                    REG_DIR:      dir_q      <= wdata;
                    REG_RISE_EN:  rise_en_q  <= wdata;
                    REG_FALL_EN:  fall_en_q  <= wdata;
                    REG_OUT_SET:  data_out_q <= data_out_q | wdata;
                    REG_OUT_CLR:  data_out_q <= data_out_q & ~wdata;
                    default:      ;
                endcase
            end
        end
    end

    always_comb begin
        rd_sel = '0;
        case (idx)
            REG_DATA_IN:  rd_sel = sync_val;
            REG_DATA_OUT: rd_sel = data_out_q;
            REG_DIR:      rd_sel = dir_q;
            REG_RISE_EN:  rd_sel = rise_en_q;
            REG_FALL_EN:  rd_sel = fall_en_q;
            REG_STATUS:   rd_sel = status_q;
            default:      rd_sel = '0;
        endcase
        rdata = '0;
        if (re) begin
            rdata[NGPIO-1:0] = rd_sel;
        end
    end

    assign bus.pRDATA  = rdata;
    assign bus.pREADY  = 1'b1;
    assign bus.pSLVERR = err;

    assign gpio_out = data_out_q;
    assign gpio_oe  = dir_q;
    assign irq      = |status_q;

endmodule
